// File: rtl/rr_lmsm_sequencer_if.sv
// Upstream (ID->RR) and downstream (micro-op) signals of the LM/SM sequencer.
// master = pipeline/environment side, slave = sequencer side.
interface rr_lmsm_sequencer_if;
  logic        id_valid;
  logic [15:0] id_instr;
  logic [15:0] id_pc;
  logic [9:0]  id_cntrl;
  logic        id_stall;

  logic        uop_valid;
  logic [15:0] uop_instr;
  logic [15:0] uop_pc;
  logic [9:0]  uop_cntrl;
  logic        uop_first;
  logic        uop_last;

  modport master (
    output id_valid, id_instr, id_pc, id_cntrl,
    input  id_stall,
    input  uop_valid, uop_instr, uop_pc, uop_cntrl, uop_first, uop_last
  );

  modport slave (
    input  id_valid, id_instr, id_pc, id_cntrl,
    output id_stall,
    output uop_valid, uop_instr, uop_pc, uop_cntrl, uop_first, uop_last
  );
endinterface

// File: rtl/rr_lmsm_sequencer.sv
// Cracks LM/SM into one LW/SW micro-op per set mask bit (lowest register first);
// other instructions pass through with one cycle of registered latency.
module rr_lmsm_sequencer #(
  parameter logic [3:0] OP_LM = 4'b0110,
  parameter logic [3:0] OP_SM = 4'b0111,
  parameter logic [3:0] OP_LW = 4'b0100,
  parameter logic [3:0] OP_SW = 4'b0101
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall_in,
  input  logic                 flush,
  output logic                 busy,
  rr_lmsm_sequencer_if.slave   bus
);

  typedef enum logic [0:0] {StIdle, StSeq} state_e;

  state_e      state_q;
  logic [7:0]  pending_q;
  logic [2:0]  off_q;
  logic [2:0]  ra_q;
  logic        is_sm_q;

  logic        uop_valid_q;
  logic [15:0] uop_instr_q;
  logic [15:0] uop_pc_q;
  logic [9:0]  uop_cntrl_q;
  logic        uop_first_q;
  logic        uop_last_q;

  logic [3:0]  id_op;
  logic        is_multi;
  logic        in_seq;
  logic [7:0]  src_mask;
  logic [2:0]  idx;
  logic [7:0]  next_pending;
  logic        kind_sm;
  logic [2:0]  ra;
  logic [2:0]  off;
  logic [15:0] uop_word;

  logic unused_id_bit;
  assign unused_id_bit = bus.id_instr[8];

  function automatic logic [2:0] lowest_idx(input logic [7:0] m);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (m[i]) r = 3'(i);
    end
    return r;
  endfunction

  // The same micro-op datapath serves the first op (from id_*) and later ops (from latches).
  always_comb begin
    id_op        = bus.id_instr[15:12];
    is_multi     = (id_op == OP_LM) || (id_op == OP_SM);
    in_seq       = (state_q == StSeq);
    src_mask     = in_seq ? pending_q : bus.id_instr[7:0];
    idx          = lowest_idx(src_mask);
    next_pending = src_mask & ~(8'd1 << idx);
    kind_sm      = in_seq ? is_sm_q : (id_op == OP_SM);
    ra           = in_seq ? ra_q : bus.id_instr[11:9];
    off          = in_seq ? off_q + 3'd1 : 3'd0;
    uop_word     = {(kind_sm ? OP_SW : OP_LW), idx, ra, 3'b000, off};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      pending_q   <= 8'd0;
      off_q       <= 3'd0;
      ra_q        <= 3'd0;
      is_sm_q     <= 1'b0;
      uop_valid_q <= 1'b0;
      uop_instr_q <= 16'd0;
      uop_pc_q    <= 16'd0;
      uop_cntrl_q <= 10'd0;
      uop_first_q <= 1'b0;
      uop_last_q  <= 1'b0;
    end else if (flush) begin
      uop_valid_q <= 1'b0;
      state_q     <= StIdle;
      pending_q   <= 8'd0;
    end else if (!stall_in) begin
      unique case (state_q)
        StIdle: begin
          if (!bus.id_valid) begin
            uop_valid_q <= 1'b0;
          end else if (!is_multi) begin
            uop_valid_q <= 1'b1;
            uop_instr_q <= bus.id_instr;
            uop_pc_q    <= bus.id_pc;
            uop_cntrl_q <= bus.id_cntrl;
            uop_first_q <= 1'b1;
            uop_last_q  <= 1'b1;
          end else if (bus.id_instr[7:0] == 8'd0) begin
            // Empty register list: nothing to issue, instruction retires silently.
            uop_valid_q <= 1'b0;
          end else begin
            uop_valid_q <= 1'b1;
            uop_instr_q <= uop_word;
            uop_pc_q    <= bus.id_pc;
            uop_cntrl_q <= bus.id_cntrl;
            uop_first_q <= 1'b1;
            uop_last_q  <= (next_pending == 8'd0);
            pending_q   <= next_pending;
            off_q       <= 3'd0;
            ra_q        <= bus.id_instr[11:9];
            is_sm_q     <= (id_op == OP_SM);
            if (next_pending != 8'd0) state_q <= StSeq;
          end
        end
        StSeq: begin
          uop_valid_q <= 1'b1;
          uop_instr_q <= uop_word;
          uop_first_q <= 1'b0;
          uop_last_q  <= (next_pending == 8'd0);
          pending_q   <= next_pending;
          off_q       <= off;
          if (next_pending == 8'd0) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy          = (state_q == StSeq);
  assign bus.id_stall  = stall_in | (state_q == StSeq);
  assign bus.uop_valid = uop_valid_q;
  assign bus.uop_instr = uop_instr_q;
  assign bus.uop_pc    = uop_pc_q;
  assign bus.uop_cntrl = uop_cntrl_q;
  assign bus.uop_first = uop_first_q;
  assign bus.uop_last  = uop_last_q;

endmodule

// File: tb/tb_rr_lmsm_sequencer.sv
// Directed bench for rr_lmsm_sequencer: pass-through, LM/SM cracking, stall, flush, reset.
module tb_rr_lmsm_sequencer;
  logic clk;
  logic rst;
  logic stall_in;
  logic flush;
  logic busy;

  int n_checks;
  int n_errors;

  rr_lmsm_sequencer_if bus ();

  rr_lmsm_sequencer dut (
    .clk      (clk),
    .rst      (rst),
    .stall_in (stall_in),
    .flush    (flush),
    .busy     (busy),
    .bus      (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Outputs are sampled 1 time unit after the active edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] enc_multi(input logic sm, input logic [2:0] ra,
                                            input logic [7:0] mask);
    return {(sm ? 4'b0111 : 4'b0110), ra, 1'b0, mask};
  endfunction

  function automatic logic [15:0] enc_uop(input logic sm, input logic [2:0] ri,
                                          input logic [2:0] ra, input logic [2:0] off);
    return {(sm ? 4'b0101 : 4'b0100), ri, ra, 3'b000, off};
  endfunction

  task automatic check_uop(input string tag, input logic [15:0] instr, input logic first,
                           input logic last, input logic stall);
    check_eq({tag, ".valid"}, 16'(bus.uop_valid), 16'd1);
    check_eq({tag, ".instr"}, bus.uop_instr, instr);
    check_eq({tag, ".first"}, 16'(bus.uop_first), 16'(first));
    check_eq({tag, ".last"}, 16'(bus.uop_last), 16'(last));
    check_eq({tag, ".id_stall"}, 16'(bus.id_stall), 16'(stall));
  endtask

  task automatic drive(input logic v, input logic [15:0] instr, input logic [15:0] pc,
                       input logic [9:0] cntrl);
    bus.id_valid = v;
    bus.id_instr = instr;
    bus.id_pc    = pc;
    bus.id_cntrl = cntrl;
  endtask

  initial begin
    logic [15:0] adds [3];
    logic [7:0]  sm_stall_regs;
    n_checks = 0;
    n_errors = 0;
    adds[0] = 16'h0123;
    adds[1] = 16'h0A5C;
    adds[2] = 16'h0FFF;
    rst = 1'b1;
    stall_in = 1'b0;
    flush = 1'b0;
    drive(1'b0, 16'h0000, 16'h0000, 10'h000);
    step();
    step();
    check_eq("reset.valid", 16'(bus.uop_valid), 16'd0);
    check_eq("reset.instr", bus.uop_instr, 16'h0000);
    check_eq("reset.first_last", 16'({bus.uop_first, bus.uop_last}), 16'd0);
    check_eq("reset.busy", 16'(busy), 16'd0);
    check_eq("reset.id_stall", 16'(bus.id_stall), 16'd0);
    rst = 1'b0;
    step();
    check_eq("idle_novalid.valid", 16'(bus.uop_valid), 16'd0);

    // 1: ADD pass-through stream
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, adds[i], 16'h0010 + 16'(i), 10'h3A0 + 10'(i));
      step();
      check_uop($sformatf("add%0d", i), adds[i], 1'b1, 1'b1, 1'b0);
      check_eq($sformatf("add%0d.pc", i), bus.uop_pc, 16'h0010 + 16'(i));
      check_eq($sformatf("add%0d.cntrl", i), 16'(bus.uop_cntrl), 16'h03A0 + 16'(i));
    end

    // 2: LM R2, mask 1010_0100 -> R2/0, R5/1, R7/2
    drive(1'b1, enc_multi(1'b0, 3'd2, 8'b1010_0100), 16'h0100, 10'h155);
    step();
    check_uop("lm0", enc_uop(1'b0, 3'd2, 3'd2, 3'd0), 1'b1, 1'b0, 1'b1);
    check_eq("lm0.busy", 16'(busy), 16'd1);
    drive(1'b1, 16'h0777, 16'h0102, 10'h0AA);
    step();
    check_uop("lm1", enc_uop(1'b0, 3'd5, 3'd2, 3'd1), 1'b0, 1'b0, 1'b1);
    check_eq("lm1.pc", bus.uop_pc, 16'h0100);
    check_eq("lm1.cntrl", 16'(bus.uop_cntrl), 16'h0155);
    step();
    check_uop("lm2", enc_uop(1'b0, 3'd7, 3'd2, 3'd2), 1'b0, 1'b1, 1'b0);
    check_eq("lm2.busy", 16'(busy), 16'd0);
    step();
    check_uop("lm_next", 16'h0777, 1'b1, 1'b1, 1'b0);
    check_eq("lm_next.pc", bus.uop_pc, 16'h0102);

    // 3: SM with empty mask is consumed silently
    drive(1'b1, enc_multi(1'b1, 3'd1, 8'h00), 16'h0200, 10'h001);
    step();
    check_eq("sm_empty.valid", 16'(bus.uop_valid), 16'd0);
    check_eq("sm_empty.id_stall", 16'(bus.id_stall), 16'd0);
    drive(1'b1, 16'h0456, 16'h0202, 10'h002);
    step();
    check_uop("sm_empty_next", 16'h0456, 1'b1, 1'b1, 1'b0);

    // 4: SM R3 mask FF, stall for 2 cycles during the 3rd micro-op
    drive(1'b1, enc_multi(1'b1, 3'd3, 8'hFF), 16'h0300, 10'h2F0);
    sm_stall_regs = 8'hFF;
    for (int i = 0; i < 8; i++) begin
      step();
      check_uop($sformatf("smff%0d", i), enc_uop(1'b1, 3'(i), 3'd3, 3'(i)), i == 0, i == 7,
                i != 7);
      check_eq($sformatf("smff%0d.pc", i), bus.uop_pc, 16'h0300);
      if (i == 0) drive(1'b1, 16'h0999, 16'h0304, 10'h004);
      if (i == 2) begin
        stall_in = 1'b1;
        for (int s = 0; s < 2; s++) begin
          step();
          check_uop($sformatf("smff_hold%0d", s), enc_uop(1'b1, 3'd2, 3'd3, 3'd2), 1'b0, 1'b0,
                    1'b1);
        end
        stall_in = 1'b0;
      end
    end
    step();
    check_uop("smff_next", 16'h0999, 1'b1, 1'b1, 1'b0);

    // 5: LM R4 mask F0 flushed after the 2nd micro-op
    drive(1'b1, enc_multi(1'b0, 3'd4, 8'hF0), 16'h0400, 10'h000);
    step();
    check_uop("lmf0", enc_uop(1'b0, 3'd4, 3'd4, 3'd0), 1'b1, 1'b0, 1'b1);
    drive(1'b1, 16'h0BBB, 16'h0402, 10'h000);
    step();
    check_uop("lmf1", enc_uop(1'b0, 3'd5, 3'd4, 3'd1), 1'b0, 1'b0, 1'b1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check_eq("flush.valid", 16'(bus.uop_valid), 16'd0);
    check_eq("flush.busy", 16'(busy), 16'd0);
    check_eq("flush.id_stall", 16'(bus.id_stall), 16'd0);
    drive(1'b1, 16'h0CCC, 16'h0500, 10'h000);
    step();
    check_uop("flush_next", 16'h0CCC, 1'b1, 1'b1, 1'b0);

    // 6: reset mid-sequence
    drive(1'b1, enc_multi(1'b0, 3'd0, 8'h0F), 16'h0600, 10'h3FF);
    step();
    check_uop("lmr0", enc_uop(1'b0, 3'd0, 3'd0, 3'd0), 1'b1, 1'b0, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_eq("rst_mid.valid", 16'(bus.uop_valid), 16'd0);
    check_eq("rst_mid.instr", bus.uop_instr, 16'h0000);
    check_eq("rst_mid.pc", bus.uop_pc, 16'h0000);
    check_eq("rst_mid.cntrl", 16'(bus.uop_cntrl), 16'h0000);
    check_eq("rst_mid.first_last", 16'({bus.uop_first, bus.uop_last}), 16'd0);
    check_eq("rst_mid.busy", 16'(busy), 16'd0);
    check_eq("rst_mid.id_stall", 16'(bus.id_stall), 16'd0);
    drive(1'b1, 16'h0DDD, 16'h0700, 10'h011);
    step();
    check_uop("rst_next", 16'h0DDD, 1'b1, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
